// File: rtl/tt10_pkg.sv
// Shared definitions for the tt10 two-stage XOR/shift pipeline.
// Holds the default data width and the matching data-word type.
package tt10_pkg;

   localparam int unsigned TT10_WIDTH = 8;

   typedef logic [TT10_WIDTH-1:0] word_t;

endpackage

// File: rtl/tt10_xor_shift.sv
// Combinational kernel: XOR the operands, then shift left by one when
// the MSB of operand a is set. The MSB of b or of the XOR never decides.
module tt10_xor_shift
   import tt10_pkg::*;
#(
   parameter int unsigned WIDTH = TT10_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c
);

   logic [WIDTH-1:0] x;

   always_comb begin
      x = a ^ b;
      c = x;
      // The shifted-out MSB of x is dropped; the result never widens.
      if (a[WIDTH-1]) begin
         c = {x[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/tt10.sv
// Top level: operand register stage, kernel instance, result register stage.
// A synchronous reset clears both stages so no in-flight result survives it.
module tt10
   import tt10_pkg::*;
#(
   parameter int unsigned WIDTH = TT10_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ui_in,
   input  logic [WIDTH-1:0] uio_in,
   output logic [WIDTH-1:0] uo_out
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_d;
   logic [WIDTH-1:0] c_q;
   logic [WIDTH-1:0] c_d;
   logic [WIDTH-1:0] kernel_c;

   tt10_xor_shift #(
      .WIDTH (WIDTH)
   ) u_xor_shift (
      .a (a_q),
      .b (b_q),
      .c (kernel_c)
   );

   always_comb begin
      a_d = ui_in;
      b_d = uio_in;
      c_d = kernel_c;
   end

   // Reset wins over capture, so zeroed operands also give a zero result.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
      end
   end

   assign uo_out = c_q;

endmodule

// File: tb/tb_tt10.sv
// Self-checking bench for tt10: directed vector table, a glitch sequence,
// and randomized traffic checked every cycle against a reference model.
module tb_tt10;
   import tt10_pkg::*;

   logic  clk;
   logic  rst;
   word_t ui_in;
   word_t uio_in;
   word_t uo_out;

   int tests_run  = 0;
   int fail_count = 0;

   tt10 #(
      .WIDTH (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic  rst;
      word_t a;
      word_t b;
      word_t exp_out;
   } vec_t;

   // Reference function written straight from the arithmetic rule.
   function automatic word_t refResult(input word_t a, input word_t b);
      int x;
      x = int'(a) ^ int'(b);
      if (a >= 8'h80) x = (x * 2) % 256;
      return word_t'(x);
   endfunction

   task automatic checkOutput(input string name, input word_t expected);
      tests_run++;
      if (uo_out !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s @%0t: uo_out=%h expected=%h", name, $time, uo_out, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input word_t a, input word_t b);
      @(negedge clk);
      rst    = r;
      ui_in  = a;
      uio_in = b;
   endtask

   // Per-cycle model: the result after an edge is the function of the
   // operands sampled one edge earlier, and zero if either edge saw reset.
   logic  prev_valid = 1'b0;
   logic  prev_rst;
   word_t prev_a;
   word_t prev_b;
   logic  cur_rst;
   word_t cur_a;
   word_t cur_b;
   word_t model_exp;

   always @(posedge clk) begin
      cur_rst = rst;
      cur_a   = ui_in;
      cur_b   = uio_in;
      #1;
      if (cur_rst || prev_valid) begin
         if (cur_rst || prev_rst) model_exp = 8'h00;
         else                     model_exp = refResult(prev_a, prev_b);
         checkOutput("model", model_exp);
      end
      prev_rst   = cur_rst;
      prev_a     = cur_a;
      prev_b     = cur_b;
      prev_valid = 1'b1;
   end

   vec_t vecs[15];

   initial begin
      rst    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      vecs[0]  = '{1'b1, 8'h00, 8'h00, 8'h00};
      vecs[1]  = '{1'b1, 8'h00, 8'h00, 8'h00};
      vecs[2]  = '{1'b0, 8'h55, 8'h33, 8'h00};
      vecs[3]  = '{1'b0, 8'hD5, 8'h33, 8'h66};
      vecs[4]  = '{1'b0, 8'h7F, 8'h00, 8'hCC};
      vecs[5]  = '{1'b0, 8'hC1, 8'h40, 8'h7F};
      vecs[6]  = '{1'b0, 8'hFF, 8'hFF, 8'h02};
      vecs[7]  = '{1'b0, 8'h80, 8'h00, 8'h00};
      vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'h00};
      vecs[9]  = '{1'b0, 8'h12, 8'h34, 8'h00};
      vecs[10] = '{1'b0, 8'hAB, 8'hCD, 8'h26};
      vecs[11] = '{1'b1, 8'h55, 8'h33, 8'h00};
      vecs[12] = '{1'b0, 8'h66, 8'h00, 8'h00};
      vecs[13] = '{1'b0, 8'h01, 8'h03, 8'h66};
      vecs[14] = '{1'b0, 8'h00, 8'h00, 8'h02};

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].a, vecs[i].b);
         @(posedge clk);
         #2;
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_out);
      end

      // Glitch on ui_in between edges must not be captured.
      applyStimulus(1'b0, 8'h55, 8'h33);
      #1 ui_in = 8'hFF;
      #1 ui_in = 8'h80;
      #1 ui_in = 8'h55;
      @(posedge clk);
      applyStimulus(1'b0, 8'h00, 8'h00);
      @(posedge clk);
      #2;
      checkOutput("glitch", 8'h66);

      // Randomized traffic with occasional resets and A == B pairs.
      for (int i = 0; i < 300; i++) begin
         word_t ra;
         word_t rb;
         ra = word_t'($urandom_range(255));
         rb = ($urandom_range(7) == 0) ? ra : word_t'($urandom_range(255));
         applyStimulus($urandom_range(15) == 0, ra, rb);
      end

      applyStimulus(1'b0, 8'h00, 8'h00);
      @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
